ysyx_24100005_mem_arb: RTL

//  Shares the single NPC data-memory read/write port between the IFU (fetch) and the LSU (load/store).

---
 rtl/ysyx_24100005_mem_arb_if.sv | 43 ++++
 rtl/ysyx_24100005_mem_arb.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ysyx_24100005_mem_arb_if.sv
// ysyx_24100005_mem_arb_if: IFU/LSU request channels and shared data-memory port
interface ysyx_24100005_mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_rdata;
    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_wen;
    logic [1:0]        lsu_size;
    logic              lsu_unsigned;
    logic [DATA_W-1:0] lsu_wdata;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_resp_err;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_wen, lsu_size,
               lsu_unsigned, lsu_wdata, mem_req_ready, mem_resp_valid, mem_resp_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata, lsu_req_ready, lsu_resp_valid,
               lsu_rdata, lsu_resp_err, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

    modport master (
        output ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_wen, lsu_size,
               lsu_unsigned, lsu_wdata, mem_req_ready, mem_resp_valid, mem_resp_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata, lsu_req_ready, lsu_resp_valid,
               lsu_rdata, lsu_resp_err, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/ysyx_24100005_mem_arb.sv
// ysyx_24100005_mem_arb: round-robin IFU/LSU arbiter onto one data-memory port with load/store lane handling
module ysyx_24100005_mem_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_24100005_mem_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t            state_q, state_d;
    logic              last_q, last_d, own_q, own_d, wen_q, wen_d, uns_q, uns_d, err_q, err_d;
    logic [1:0]        size_q, size_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;
    logic [DATA_W-1:0] raw, ld;
    logic              grant_lsu, lsu_mis, st, ifu_rdy, lsu_rdy;

    // select the addressed lane of the returned word and extend it
    always_comb begin
        raw = bus.mem_resp_rdata >> {addr_q[1:0], 3'b000};
        ld  = size_q == 2'b00 ? {{24{~uns_q & raw[7]}}, raw[7:0]} :
              size_q == 2'b01 ? {{16{~uns_q & raw[15]}}, raw[15:0]} : raw;
    end

    // arbitration in IDLE, then issue/wait/respond for the single outstanding transaction
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        own_d       = own_q;
        wen_d       = wen_q;
        uns_d       = uns_q;
        err_d       = err_q;
        size_d      = size_q;
        wmask_d     = wmask_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        ifu_rdy     = 1'b0;
        lsu_rdy     = 1'b0;
        grant_lsu   = bus.lsu_req_valid & (~bus.ifu_req_valid | ~last_q);
        lsu_mis     = bus.lsu_size == 2'b11 || (bus.lsu_size == 2'b01 && bus.lsu_addr[0]) ||
                      (bus.lsu_size == 2'b10 && bus.lsu_addr[1:0] != 2'b00);
        st          = grant_lsu & bus.lsu_wen & ~lsu_mis;
        case (state_q)
            IDLE: if (!rst && (bus.ifu_req_valid || bus.lsu_req_valid)) begin
                ifu_rdy     = ~grant_lsu;
                lsu_rdy     = grant_lsu;
                own_d       = grant_lsu;
                last_d      = grant_lsu;
                addr_d      = grant_lsu ? bus.lsu_addr : bus.ifu_addr;
                wen_d       = st;
                size_d      = grant_lsu ? bus.lsu_size : 2'b10;
                uns_d       = bus.lsu_unsigned;
                wdata_d     = st ? bus.lsu_wdata << {bus.lsu_addr[1:0], 3'b000} : '0;
                wmask_d     = !st ? 4'b0000 :
                              bus.lsu_size == 2'b00 ? 4'b0001 << bus.lsu_addr[1:0] :
                              bus.lsu_size == 2'b01 ? 4'b0011 << bus.lsu_addr[1:0] : 4'b1111;
                err_d       = grant_lsu & lsu_mis;
                lsu_rdata_d = (grant_lsu & lsu_mis) ? '0 : lsu_rdata_q;
                state_d     = (grant_lsu & lsu_mis) ? RESP : ISSUE;
            end
            ISSUE: state_d = bus.mem_req_ready ? WAIT : ISSUE;
            WAIT: if (bus.mem_resp_valid) begin
                ifu_rdata_d = own_q ? ifu_rdata_q : bus.mem_resp_rdata;
                lsu_rdata_d = !own_q ? lsu_rdata_q : wen_q ? '0 : ld;
                state_d     = RESP;
            end
            default: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // transaction state and captured response data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b0;
            own_q       <= 1'b0;
            wen_q       <= 1'b0;
            uns_q       <= 1'b0;
            err_q       <= 1'b0;
            size_q      <= 2'b00;
            wmask_q     <= 4'b0000;
            addr_q      <= '0;
            wdata_q     <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            own_q       <= own_d;
            wen_q       <= wen_d;
            uns_q       <= uns_d;
            err_q       <= err_d;
            size_q      <= size_d;
            wmask_q     <= wmask_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    assign bus.ifu_req_ready  = ifu_rdy;
    assign bus.lsu_req_ready  = lsu_rdy;
    assign bus.ifu_resp_valid = state_q == RESP && !own_q;
    assign bus.lsu_resp_valid = state_q == RESP && own_q;
    assign bus.lsu_resp_err   = state_q == RESP && err_q;
    assign bus.ifu_rdata      = ifu_rdata_q;
    assign bus.lsu_rdata      = lsu_rdata_q;
    assign bus.mem_req_valid  = state_q == ISSUE;
    assign bus.mem_addr       = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_wen        = wen_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.mem_wmask      = wmask_q;
endmodule
